// File: rtl/citadel_cmd_arbiter.sv
// Shares the citadel_fpu command port between NREQ requesters and routes responses back in order.
// Optional macro CITADEL_ARB_PRIO0_EN: requester 0 gets fixed absolute priority.
module citadel_cmd_arbiter #(
   parameter int NREQ      = 2,
   parameter int CMD_W     = 160,
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NREQ-1:0]        req_valid_i,
   input  logic [NREQ*CMD_W-1:0]  req_cmd_bi,
   input  logic [NREQ-1:0]        req_wresp_i,
   output logic [NREQ-1:0]        req_ack_o,
   output logic [NREQ-1:0]        resp_valid_o,
   output logic [DATA_W-1:0]      resp_data_bo,
   output logic                   cmd_req_genfifo_req_o,
   output logic [CMD_W-1:0]       cmd_req_genfifo_rdata_bo,
   input  logic                   cmd_req_genfifo_ack_i,
   input  logic                   cmd_resp_genfifo_req_i,
   input  logic [DATA_W-1:0]      cmd_resp_genfifo_wdata_bi,
   output logic                   cmd_resp_genfifo_ack_o,
   output logic                   busy_o,
   output logic                   err_o
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW  = PW + 1;

   logic [IDW-1:0]    rr_ptr;
   logic              out_vld;
   logic [CMD_W-1:0]  out_cmd;
   logic [IDW-1:0]    tag_mem [TAG_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     tag_cnt;
   logic [NREQ-1:0]   resp_vld;
   logic [DATA_W-1:0] resp_data;
   logic              err;

   logic              free, pop, push, would_full, grant, found;
   logic [NREQ-1:0]   elig;
   logic [IDW:0]      cand;
   logic [IDW-1:0]    win, win_nxt;
   logic [CMD_W-1:0]  win_cmd;
   logic              win_wresp;

   assign pop        = cmd_resp_genfifo_req_i & (tag_cnt != '0);
   assign would_full = (tag_cnt == CW'(TAG_DEPTH)) & ~pop;
   assign free       = ~out_vld | cmd_req_genfifo_ack_i;
   assign elig       = req_valid_i & ~(req_wresp_i & {NREQ{would_full}});
   // No grant while reset is held, so no requester believes its command was taken.
   assign grant      = rst_ni & free & (|elig);

   always_comb begin
      win   = rr_ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!found && elig[cand[IDW-1:0]]) begin
            win   = cand[IDW-1:0];
            found = 1'b1;
         end
      end
`ifdef CITADEL_ARB_PRIO0_EN
      if (elig[0]) win = '0;
`endif
   end

   assign win_nxt = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

   always_comb begin
      win_cmd   = '0;
      win_wresp = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == IDW'(k)) begin
            win_cmd   = req_cmd_bi[k*CMD_W +: CMD_W];
            win_wresp = req_wresp_i[k];
         end
      end
   end

   assign push      = grant & win_wresp;
   assign req_ack_o = grant ? (NREQ'(1) << win) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr    <= '0;
         out_vld   <= 1'b0;
         out_cmd   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_cnt   <= '0;
         resp_vld  <= '0;
         resp_data <= '0;
         err       <= 1'b0;
      end else begin
         if (grant) begin
            out_vld <= 1'b1;
            out_cmd <= win_cmd;
`ifdef CITADEL_ARB_PRIO0_EN
            if (win != '0) rr_ptr <= win_nxt;
`else
            rr_ptr <= win_nxt;
`endif
         end else if (cmd_req_genfifo_ack_i) begin
            out_vld <= 1'b0;
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         tag_cnt  <= tag_cnt + CW'(push) - CW'(pop);
         resp_vld <= pop ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
         if (pop) resp_data <= cmd_resp_genfifo_wdata_bi;
         // A response with nothing outstanding is dropped and flagged until reset.
         if (cmd_resp_genfifo_req_i & ~pop) err <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) tag_mem[wr_ptr] <= win;
   end

   assign cmd_req_genfifo_req_o    = out_vld;
   assign cmd_req_genfifo_rdata_bo = out_cmd;
   assign cmd_resp_genfifo_ack_o   = 1'b1;
   assign resp_valid_o             = resp_vld;
   assign resp_data_bo             = resp_data;
   assign busy_o                   = out_vld | (tag_cnt != '0);
   assign err_o                    = err;
endmodule

// File: tb/tb_citadel_cmd_arbiter.sv
// Bench for citadel_cmd_arbiter: directed table, corner sequences, random traffic vs. queue model.
module tb_citadel_cmd_arbiter;
   localparam int NREQ = 2, CMD_W = 160, DATA_W = 32, TAG_DEPTH = 8;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [NREQ-1:0]       req_valid_i, req_wresp_i, req_ack_o, resp_valid_o;
   logic [NREQ*CMD_W-1:0] req_cmd_bi;
   logic [DATA_W-1:0]     resp_data_bo, cmd_resp_genfifo_wdata_bi;
   logic                  cmd_req_genfifo_req_o, cmd_req_genfifo_ack_i;
   logic [CMD_W-1:0]      cmd_req_genfifo_rdata_bo;
   logic                  cmd_resp_genfifo_req_i, cmd_resp_genfifo_ack_o, busy_o, err_o;
   logic [CMD_W-1:0]      cmd_r [NREQ];

   always #5 clk_i = ~clk_i;

   always_comb begin
      req_cmd_bi = '0;
      for (int k = 0; k < NREQ; k++) req_cmd_bi[k*CMD_W +: CMD_W] = cmd_r[k];
   end

   citadel_cmd_arbiter #(.NREQ(NREQ), .CMD_W(CMD_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_cmd_bi(req_cmd_bi), .req_wresp_i(req_wresp_i),
      .req_ack_o(req_ack_o), .resp_valid_o(resp_valid_o), .resp_data_bo(resp_data_bo),
      .cmd_req_genfifo_req_o(cmd_req_genfifo_req_o), .cmd_req_genfifo_rdata_bo(cmd_req_genfifo_rdata_bo),
      .cmd_req_genfifo_ack_i(cmd_req_genfifo_ack_i), .cmd_resp_genfifo_req_i(cmd_resp_genfifo_req_i),
      .cmd_resp_genfifo_wdata_bi(cmd_resp_genfifo_wdata_bi), .cmd_resp_genfifo_ack_o(cmd_resp_genfifo_ack_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   int total = 0, bad = 0;

   // reference model: output stage, outstanding-ID queue, rotating pointer
   int                m_rr, m_win;
   bit                m_vld, m_err;
   logic [CMD_W-1:0]  m_cmd;
   int                m_q[$];
   logic [NREQ-1:0]   m_rv;
   logic [DATA_W-1:0] m_data;

   typedef struct {
      logic [NREQ-1:0]   rv, wr;
      logic              fack, rreq;
      logic [DATA_W-1:0] rdat;
      logic [NREQ-1:0]   ack_rr, ack_p0, rvo;
      logic              err;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] wr, input logic fa,
                        input logic rr, input logic [DATA_W-1:0] d);
      req_valid_i = rv; req_wresp_i = wr; cmd_req_genfifo_ack_i = fa;
      cmd_resp_genfifo_req_i = rr; cmd_resp_genfifo_wdata_bi = d;
   endtask

   task automatic do_cycle();
      bit                pop, full, free, rreq, fack, wr;
      logic [NREQ-1:0]   elig, exp_ack;
      logic [DATA_W-1:0] rdat;
      logic [CMD_W-1:0]  cmdw;
      int                win;
      #1;
      pop  = cmd_resp_genfifo_req_i && (m_q.size() > 0);
      full = (m_q.size() == TAG_DEPTH) && !pop;
      free = !m_vld || cmd_req_genfifo_ack_i;
      for (int k = 0; k < NREQ; k++) elig[k] = req_valid_i[k] && !(req_wresp_i[k] && full);
      win = -1;
      if (free) begin
`ifdef CITADEL_ARB_PRIO0_EN
         if (elig[0]) win = 0;
`endif
         for (int i = 0; i < NREQ; i++)
            if (win < 0 && elig[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
      end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("req_ack", req_ack_o, exp_ack);
      chk("cmd_req", cmd_req_genfifo_req_o, m_vld);
      if (m_vld) chk("cmd_rdata", cmd_req_genfifo_rdata_bo, m_cmd);
      chk("resp_valid", resp_valid_o, m_rv);
      chk("resp_data", resp_data_bo, m_data);
      chk("err", err_o, m_err);
      chk("busy", busy_o, (m_vld || m_q.size() > 0));
      chk("resp_ack", cmd_resp_genfifo_ack_o, 1'b1);
      m_win = win;
      rreq = cmd_resp_genfifo_req_i; fack = cmd_req_genfifo_ack_i; rdat = cmd_resp_genfifo_wdata_bi;
      wr = (win >= 0) ? req_wresp_i[win] : 1'b0;
      cmdw = (win >= 0) ? cmd_r[win] : '0;
      @(posedge clk_i);
      m_rv = '0;
      if (pop) begin
         m_rv[m_q[0]] = 1'b1;
         m_data = rdat;
         void'(m_q.pop_front());
      end else if (rreq) m_err = 1'b1;
      if (win >= 0) begin
         m_vld = 1'b1;
         m_cmd = cmdw;
         if (wr) m_q.push_back(win);
`ifdef CITADEL_ARB_PRIO0_EN
         if (win != 0) m_rr = (win + 1) % NREQ;
`else
         m_rr = (win + 1) % NREQ;
`endif
      end else if (fack) m_vld = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      drive('0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < NREQ; k++) cmd_r[k] = '0;
      #2;
      chk("rst_ack", req_ack_o, '0);
      chk("rst_cmd_req", cmd_req_genfifo_req_o, 1'b0);
      chk("rst_rdata", cmd_req_genfifo_rdata_bo, '0);
      chk("rst_resp_valid", resp_valid_o, '0);
      chk("rst_resp_data", resp_data_bo, '0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_resp_ack", cmd_resp_genfifo_ack_o, 1'b1);
      m_rr = 0; m_vld = 1'b0; m_cmd = '0; m_q.delete(); m_rv = '0; m_data = '0; m_err = 1'b0; m_win = -1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      bit pend [NREQ];
      rst_ni = 1'b1;
      drive('0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < NREQ; k++) cmd_r[k] = '0;
      //          rv     wr    fack  rreq  rdat           ack_rr ack_p0 rvo    err
      tbl[0]  = '{2'b01, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b0};
      tbl[1]  = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0};
      tbl[2]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h3F800000, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 2'b01, 2'b01, 1'b0};
      tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b0};
      tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b10, 2'b01, 2'b00, 1'b0};
      tbl[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0};
      tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b0};
      tbl[8]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0,        2'b01, 2'b01, 2'b00, 1'b0};
      tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hDEAD,     2'b00, 2'b00, 2'b00, 1'b0};
      tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 2'b00, 2'b00, 1'b1};
      #1;
      do_reset();

      cmd_r[0] = CMD_W'(8'hA5);
      cmd_r[1] = CMD_W'(8'h5A);
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rv, tbl[i].wr, tbl[i].fack, tbl[i].rreq, tbl[i].rdat);
         #1;
`ifdef CITADEL_ARB_PRIO0_EN
         chk($sformatf("tbl%0d_ack", i), req_ack_o, tbl[i].ack_p0);
`else
         chk($sformatf("tbl%0d_ack", i), req_ack_o, tbl[i].ack_rr);
`endif
         chk($sformatf("tbl%0d_rv", i), resp_valid_o, tbl[i].rvo);
         chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err);
         do_cycle();
      end

      // order FIFO fill, masking of wresp requesters, grant on the pop cycle
      do_reset();
      for (int i = 0; i < TAG_DEPTH; i++) begin
         cmd_r[0] = CMD_W'(i + 16);
         drive(2'b01, 2'b01, 1'b1, 1'b0, '0);
         #1;
         chk("fill_ack", req_ack_o, 2'b01);
         do_cycle();
      end
      cmd_r[0] = CMD_W'(8'h99);
      cmd_r[1] = CMD_W'(8'h77);
      drive(2'b11, 2'b01, 1'b1, 1'b0, '0);
      #1;
      chk("full_mask_ack", req_ack_o, 2'b10);
      chk("full_busy", busy_o, 1'b1);
      do_cycle();
      drive(2'b01, 2'b01, 1'b1, 1'b1, 32'h55);
      #1;
      chk("pop_grant_ack", req_ack_o, 2'b01);
      do_cycle();

      // interleaved response routing
      do_reset();
      drive(2'b10, 2'b10, 1'b1, 1'b0, '0); #1; chk("route_g0", req_ack_o, 2'b10); do_cycle();
      drive(2'b01, 2'b01, 1'b1, 1'b0, '0); #1; chk("route_g1", req_ack_o, 2'b01); do_cycle();
      drive(2'b10, 2'b10, 1'b1, 1'b0, '0); #1; chk("route_g2", req_ack_o, 2'b10); do_cycle();
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h1); do_cycle();
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h2); #1;
      chk("route_rv0", resp_valid_o, 2'b10); chk("route_d0", resp_data_bo, 32'h1); do_cycle();
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h3); #1;
      chk("route_rv1", resp_valid_o, 2'b01); chk("route_d1", resp_data_bo, 32'h2); do_cycle();
      drive(2'b00, 2'b00, 1'b1, 1'b0, '0); #1;
      chk("route_rv2", resp_valid_o, 2'b10); chk("route_d2", resp_data_bo, 32'h3); do_cycle();
      #1;
      chk("route_idle_rv", resp_valid_o, 2'b00); chk("route_hold_d", resp_data_bo, 32'h3);
      chk("route_err", err_o, 1'b0);
      do_cycle();

      // random traffic with an asynchronous reset in the middle
      do_reset();
      for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            do_reset();
            for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
         end
         for (int k = 0; k < NREQ; k++) begin
            if (pend[k] && m_win == k) pend[k] = 1'b0;
            if (!pend[k] && $urandom_range(0, 2) != 0) begin
               pend[k] = 1'b1;
               cmd_r[k] = {$urandom, $urandom, $urandom, $urandom, $urandom};
               req_wresp_i[k] = ($urandom_range(0, 2) != 0);
            end
            req_valid_i[k] = pend[k];
         end
         cmd_req_genfifo_ack_i     = ($urandom_range(0, 3) != 0);
         cmd_resp_genfifo_req_i    = ($urandom_range(0, 3) == 0);
         cmd_resp_genfifo_wdata_bi = $urandom;
         do_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/citadel_cmd_arbiter.md
Name: citadel_cmd_arbiter

Overview:
Shares the single citadel_fpu command port between NREQ independent requesters, such as the UDM CSR path and local command sequencers.
- Round-robin arbitrates command requests and drives the fpu cmd_req genfifo interface from a registered output stage.
- Records the requester ID of every command that expects a response in an order FIFO, then routes each fpu response back to its originator in order.
- Sits between the requesters and the citadel_fpu instance in the board top.

Parameters:
NREQ, 2, number of requesters (2..8)
CMD_W, 160, width of packed citadel_fpu_cmd_req_struct
DATA_W, 32, fpu response data width
TAG_DEPTH, 8, order-FIFO depth (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  per-requester command valid
req_cmd_bi  in  NREQ*CMD_W  per-requester command; slice k = [k*CMD_W +: CMD_W]
req_wresp_i  in  NREQ  command expects an fpu response
req_ack_o  out  NREQ  one-hot grant; command taken this cycle
resp_valid_o  out  NREQ  one-hot response strobe
resp_data_bo  out  DATA_W  response data, shared by all requesters
cmd_req_genfifo_req_o  out  1  command valid to fpu
cmd_req_genfifo_rdata_bo  out  CMD_W  command to fpu
cmd_req_genfifo_ack_i  in  1  fpu accepted command
cmd_resp_genfifo_req_i  in  1  fpu response valid
cmd_resp_genfifo_wdata_bi  in  DATA_W  fpu response data
cmd_resp_genfifo_ack_o  out  1  always 1; responses are never back-pressured
busy_o  out  1  output stage full or order FIFO non-empty
err_o  out  1  sticky: fpu response arrived with no outstanding tag

Behaviour:
Reset:
- All outputs 0 except cmd_resp_genfifo_ack_o=1.
- Round-robin pointer = 0; order FIFO empty; output stage empty.

Output stage:
- One CMD_W register plus a valid flag.
- "free" = (valid==0) | (cmd_req_genfifo_req_o & cmd_req_genfifo_ack_i).

Eligibility:
- Requester k is eligible when req_valid_i[k] and NOT (req_wresp_i[k] and order FIFO would be full).
- "would be full" = count==TAG_DEPTH and no pop this cycle.

Grant:
- Issued only when free.
- Winner = first eligible index at or after rr_ptr, modulo NREQ.
- req_ack_o[winner]=1 combinationally in the same cycle.
- On the next edge: the command is loaded into the output stage, valid=1, rr_ptr=winner+1 (wraps NREQ-1 -> 0).
- If the winner's wresp=1, winner's ID is pushed into the order FIFO on the same edge.

Latency and handshake:
- Grant at cycle t -> cmd_req_genfifo_req_o=1 at t+1.
- Back-to-back grants possible when the fpu acks every cycle, giving 1 command/cycle.
- While valid and not acked: cmd_req_genfifo_req_o and rdata are held stable.
- A requester must hold req_valid_i and req_cmd_bi stable until its req_ack_o.

Responses:
- On cmd_resp_genfifo_req_i with the order FIFO non-empty: pop the head ID.
- At the next edge: resp_valid_o[ID]=1 for exactly one cycle, and resp_data_bo = data registered from cmd_resp_genfifo_wdata_bi.
- resp_data_bo holds its value until the next response.

Boundary conditions:
- Response with the order FIFO empty: data dropped, err_o set, cleared only by reset.
- Order FIFO push and pop in the same cycle: count unchanged, both performed; this is legal when full.
- Order FIFO full: only wresp=1 requesters are masked; wresp=0 commands still proceed.
- No eligible requester: no grant; rr_ptr unchanged.
- Asynchronous reset mid-operation: the output stage and order FIFO are cleared immediately, and in-flight responses are lost. The fpu must be reset by the same reset.

Optional Feature:
CITADEL_ARB_PRIO0_EN:
- Defined: requester 0 has fixed absolute priority whenever eligible, and rr_ptr does not advance on its grants. Requesters 1..NREQ-1 round-robin among themselves when 0 is idle.
- Undefined: pure round-robin over all NREQ requesters, as described above.

Test Plan:
- Single request, fpu ack tied 1: req0 cmd=0x..A5, wresp=1 at t -> req_ack_o=01 at t; genfifo_req=1, rdata=0x..A5 at t+1. Response 0x3F800000 at t+5 -> resp_valid_o=01, resp_data_bo=0x3F800000 at t+6.
- Contention: req0 and req1 valid continuously, wresp=0, ack=1 -> grants alternate 01,10,01,10, one per cycle; with CITADEL_ARB_PRIO0_EN -> grants 01 every cycle.
- Back-pressure: fpu ack held 0 for 4 cycles -> genfifo_req and rdata stable, no new req_ack_o. Ack released -> next grant in the same cycle.
- Order FIFO full: TAG_DEPTH=8, 8 wresp=1 commands, no responses -> 9th wresp=1 request stalled while a wresp=0 request from the other port is granted. One response -> stalled request granted in the same cycle as the pop.
- Response routing: interleaved commands req1,req0,req1 (all wresp=1); responses 0x1,0x2,0x3 -> resp_valid_o 10,01,10 with matching data.
- Unsolicited response: response with nothing outstanding -> err_o=1 and stays 1; no resp_valid_o. Reset -> err_o=0.
